// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with byte-lane writes, registered reads,
// port-A-wins write collisions and an optional post-reset zeroing sweep.
module dual_port_ram #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1 << ADDR_WIDTH,
  parameter bit RDW_NEW        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    busy,
  input  logic                    a_en,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ready;
  logic                    a_in, b_in;
  logic                    a_wr, b_wr, a_rd, b_rd;
  logic                    same_addr;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_new, b_new, a_word, b_word;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == S_CLEAR) begin
      clr_d = clr_q + ADDR_WIDTH'(1);
      if (clr_q == LAST) begin
        state_d = S_READY;
        clr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign busy = (state_q == S_CLEAR);

  // Requests are only honoured in READY and never on a reset cycle.
  assign ready     = (state_q == S_READY) && !rst;
  assign a_in      = {1'b0, a_addr} < DEPTH_L;
  assign b_in      = {1'b0, b_addr} < DEPTH_L;
  assign a_wr      = ready && a_en && a_we && a_in;
  assign b_wr      = ready && b_en && b_we && b_in;
  assign a_rd      = ready && a_en && !a_we;
  assign b_rd      = ready && b_en && !b_we;
  assign same_addr = (a_addr == b_addr);

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // Post-write view of each reader's word, folding in the other port's lanes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign a_new[gi*8 +: 8] = (b_wr && same_addr && b_be[gi]) ? b_wdata[gi*8 +: 8]
                                                               : a_old[gi*8 +: 8];
    assign b_new[gi*8 +: 8] = (a_wr && same_addr && a_be[gi]) ? a_wdata[gi*8 +: 8]
                                                               : b_old[gi*8 +: 8];
  end

  assign a_word = !a_in ? '0 : (RDW_NEW ? a_new : a_old);
  assign b_word = !b_in ? '0 : (RDW_NEW ? b_new : b_old);

  // Port A lanes are written after port B so A wins on a shared lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem[clr_q] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (b_wr && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
          if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= a_word;
      if (b_rd) b_rdata <= b_word;
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Drives two RAM instances (DEPTH=16 old-data RDW, DEPTH=12 new-data RDW) with
// shared stimulus and checks both against a word-level reference model.
module tb_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        bsy [2];
  logic        arv [2];
  logic        brv [2];
  logic [31:0] ard [2];
  logic [31:0] brd [2];

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // model state per instance
  logic [31:0] mm  [2][16];
  int          bl  [2];
  logic [31:0] ea  [2];
  logic [31:0] eb  [2];
  logic        eva [2];
  logic        evb [2];

  always #5 clk = ~clk;

  dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .RDW_NEW(1'b0),
                  .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst(rst), .busy(bsy[0]),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(ard[0]), .a_rvalid(arv[0]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(brd[0]), .b_rvalid(brv[0]));

  dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .RDW_NEW(1'b1),
                  .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .rst(rst), .busy(bsy[1]),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(ard[1]), .a_rvalid(arv[1]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(brd[1]), .b_rvalid(brv[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Reference: sweep = DEPTH ignored cycles then all-zero memory; otherwise apply
  // both writes (A last so it wins) and read pre- or post-write words.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int          dp;
      logic [31:0] post [16];
      dp = (k == 0) ? 16 : 12;
      if (rst) begin
        bl[k]  = dp;
        ea[k]  = '0;
        eb[k]  = '0;
        eva[k] = 1'b0;
        evb[k] = 1'b0;
      end else if (bl[k] > 0) begin
        bl[k]--;
        eva[k] = 1'b0;
        evb[k] = 1'b0;
        if (bl[k] == 0) for (int j = 0; j < 16; j++) mm[k][j] = '0;
      end else begin
        for (int j = 0; j < 16; j++) post[j] = mm[k][j];
        if (b_en && b_we && int'(b_addr) < dp) post[b_addr] = wmerge(post[b_addr], b_wdata, b_be);
        if (a_en && a_we && int'(a_addr) < dp) post[a_addr] = wmerge(post[a_addr], a_wdata, a_be);
        eva[k] = a_en && !a_we;
        evb[k] = b_en && !b_we;
        if (eva[k]) ea[k] = (int'(a_addr) >= dp) ? 32'h0 : ((k == 1) ? post[a_addr] : mm[k][a_addr]);
        if (evb[k]) eb[k] = (int'(b_addr) >= dp) ? 32'h0 : ((k == 1) ? post[b_addr] : mm[k][b_addr]);
        for (int j = 0; j < 16; j++) mm[k][j] = post[j];
      end
    end
  endtask

  initial begin
    bl[0] = 0;
    bl[1] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("u%0d busy", k), {31'b0, bsy[k]}, {31'b0, bl[k] > 0});
          chk($sformatf("u%0d a_rvalid", k), {31'b0, arv[k]}, {31'b0, eva[k]});
          chk($sformatf("u%0d b_rvalid", k), {31'b0, brv[k]}, {31'b0, evb[k]});
          chk($sformatf("u%0d a_rdata", k), ard[k], ea[k]);
          chk($sformatf("u%0d b_rdata", k), brd[k], eb[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 0; a_we = 0; a_be = 0;
    b_en = 0; b_we = 0; b_be = 0;
  endtask

  task automatic a_write(input int ad, input logic [31:0] d, input logic [3:0] be);
    a_en = 1; a_we = 1; a_addr = ad[3:0]; a_wdata = d; a_be = be;
  endtask

  task automatic b_write(input int ad, input logic [31:0] d, input logic [3:0] be);
    b_en = 1; b_we = 1; b_addr = ad[3:0]; b_wdata = d; b_be = be;
  endtask

  task automatic a_read(input int ad);
    a_en = 1; a_we = 0; a_addr = ad[3:0]; a_be = 0;
  endtask

  task automatic b_read(input int ad);
    b_en = 1; b_we = 0; b_addr = ad[3:0]; b_be = 0;
  endtask

  task automatic count_busy(input string tag);
    int n0, n1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (bsy[0]) n0++;
      if (bsy[1]) n1++;
      tick();
    end
    chk({"u0 busy cycles ", tag}, n0, 16);
    chk({"u1 busy cycles ", tag}, n1, 12);
  endtask

  initial begin
    int nv;
    idle();
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    rst = 1;
    tick();
    started = 1'b1;
    chk("u0 reset a_rdata", ard[0], 32'h0);
    chk("u1 reset busy", {31'b0, bsy[1]}, 32'h1);
    tick();
    rst = 0;
    repeat (20) tick();

    // preload, then a 1-cycle reset with port A reading throughout the sweep
    for (int i = 0; i < 16; i++) begin
      a_write(i, 32'hC0DE0000 + i, 4'hF);
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    a_read(2);
    count_busy("after preload");
    idle();
    for (int i = 0; i < 16; i++) begin
      b_read(i);
      tick();
    end
    b_read(9);
    tick();
    chk("u0 cleared word 9", brd[0], 32'h0);
    idle();
    tick();

    // byte-enable write, read back through B
    a_write(5, 32'h11223344, 4'hF);
    tick();
    a_write(5, 32'hAABBCCDD, 4'b0101);
    tick();
    idle();
    b_read(5);
    tick();
    chk("u0 be merge", brd[0], 32'h11BB33DD);
    chk("u1 be merge", brd[1], 32'h11BB33DD);
    chk("u0 be rvalid", {31'b0, brv[0]}, 32'h1);
    idle();
    tick();
    chk("u0 rvalid one cycle", {31'b0, brv[0]}, 32'h0);

    // same-address write collision
    a_write(3, 32'hAAAAAAAA, 4'b0011);
    b_write(3, 32'hBBBBBBBB, 4'b0110);
    tick();
    idle();
    a_read(3);
    tick();
    chk("u0 collision", ard[0], 32'h00BBAAAA);
    chk("u1 collision", ard[1], 32'h00BBAAAA);
    idle();

    // cross-port read during write
    a_write(7, 32'h1, 4'hF);
    tick();
    a_write(7, 32'h2, 4'hF);
    b_read(7);
    tick();
    chk("u0 rdw old", brd[0], 32'h1);
    chk("u1 rdw new", brd[1], 32'h2);
    idle();

    // out-of-range on u1 (DEPTH=12), in range on u0
    a_write(13, 32'hDEADBEEF, 4'hF);
    tick();
    a_read(13);
    tick();
    chk("u1 oor rdata", ard[1], 32'h0);
    chk("u1 oor rvalid", {31'b0, arv[1]}, 32'h1);
    chk("u0 addr13 rdata", ard[0], 32'hDEADBEEF);
    idle();

    // streaming: B reads 0..15 back to back while A writes
    nv = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        b_read(i);
        a_write(15 - i, 32'h01010101 * (i + 1), 4'hF);
      end else begin
        idle();
      end
      tick();
      if (brv[0] && brv[1]) nv++;
    end
    chk("stream rvalid count", nv, 17 - 1);
    idle();

    // reset at sweep cycle 8 restarts the sweep
    rst = 1;
    tick();
    rst = 0;
    repeat (8) tick();
    rst = 1;
    tick();
    rst = 0;
    count_busy("after mid-sweep reset");
    b_read(15);
    tick();
    chk("u0 word 15 after sweep", brd[0], 32'h0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
